// File: rtl/am_demod_param_if.sv
// Sample-stream bundle for the AM demodulator.
// Source side drives samples and controls, sink returns baseband.
interface am_demod_param_if #(
  parameter int DW = 16
);
  logic          in_valid;
  logic [DW-1:0] sig_in;
  logic [DW-1:0] carrier;
  logic          mode;
  logic          dc_en;
  logic          clr;
  logic          out_valid;
  logic [DW-1:0] sig_out;

  modport master (
    output in_valid,
    output sig_in,
    output carrier,
    output mode,
    output dc_en,
    output clr,
    input  out_valid,
    input  sig_out
  );

  modport slave (
    input  in_valid,
    input  sig_in,
    input  carrier,
    input  mode,
    input  dc_en,
    input  clr,
    output out_valid,
    output sig_out
  );
endinterface

// File: rtl/am_demod_param.sv
// Coherent/envelope AM demodulator: convert, mix, boxcar
// average, optional leaky DC removal, offset-binary out.
module am_demod_param #(
  parameter int DW       = 16,
  parameter int AVG_LOG2 = 4,
  parameter int DC_SHIFT = 6
) (
  input logic             clk,
  input logic             rst,
  am_demod_param_if.slave bus
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = DW + AVG_LOG2;
  localparam int AW    = DW + DC_SHIFT;
  localparam int PW    = 2 * DW;

  localparam logic signed [DW-1:0] SMIN =
    {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] SMAX =
    {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MID =
    {1'b1, {(DW-1){1'b0}}};

  logic v1_q, v1_d;
  logic v2_q, v2_d;
  logic v3_q, v3_d;
  logic ov_q, ov_d;

  logic signed [DW-1:0] sig_s_q, sig_s_d;
  logic signed [DW-1:0] car_s_q, car_s_d;
  logic                 mode_q, mode_d;

  logic signed [DW-1:0] m_q, m_d;
  logic signed [PW-1:0] prod;
  logic signed [DW-1:0] m_coh;
  logic signed [DW-1:0] m_env;

  logic signed [SW-1:0]       sum_q, sum_d;
  logic [AVG_LOG2-1:0]        ptr_q, ptr_d;
  logic signed [DW-1:0]       box_q [DEPTH];

  logic signed [AW-1:0] dc_acc_q, dc_acc_d;
  logic signed [DW-1:0] avg;
  logic signed [DW-1:0] dc;
  logic signed [DW:0]   diff;
  logic signed [DW-1:0] y;
  logic [DW-1:0]        sig_out_q, sig_out_d;

  // S1: offset-binary to two's complement
  always_comb begin
    v1_d    = bus.in_valid & ~bus.clr;
    sig_s_d = sig_s_q;
    car_s_d = car_s_q;
    mode_d  = mode_q;
    if (v1_d) begin
      sig_s_d = {~bus.sig_in[DW-1], bus.sig_in[DW-2:0]};
      car_s_d = {~bus.carrier[DW-1], bus.carrier[DW-2:0]};
      mode_d  = bus.mode;
    end
  end

  // S2: product rescaled to Q1.(DW-1), or magnitude
  always_comb begin
    prod  = PW'(sig_s_q) * PW'(car_s_q);
    m_coh = DW'(prod >>> (DW - 1));
    if (sig_s_q == SMIN && car_s_q == SMIN) begin
      m_coh = SMAX;
    end
    m_env = sig_s_q;
    if (sig_s_q == SMIN) begin
      m_env = SMAX;
    end else if (sig_s_q[DW-1]) begin
      m_env = -sig_s_q;
    end
    v2_d = v1_q & ~bus.clr;
    m_d  = m_q;
    if (v1_q) begin
      m_d = mode_q ? m_env : m_coh;
    end
  end

  // S3: running sum over the circular history
  always_comb begin
    v3_d  = v2_q & ~bus.clr;
    sum_d = sum_q;
    ptr_d = ptr_q;
    if (bus.clr) begin
      sum_d = '0;
      ptr_d = '0;
    end else if (v2_q) begin
      sum_d = sum_q + SW'(m_q) - SW'(box_q[ptr_q]);
      ptr_d = ptr_q + AVG_LOG2'(1);
    end
  end

  // S4: leaky DC tracker uses the pre-update estimate
  always_comb begin
    avg      = DW'(sum_q >>> AVG_LOG2);
    dc       = DW'(dc_acc_q >>> DC_SHIFT);
    diff     = (DW+1)'(avg) - (DW+1)'(dc);
    dc_acc_d = dc_acc_q;
    if (bus.clr) begin
      dc_acc_d = '0;
    end else if (v3_q) begin
      dc_acc_d = dc_acc_q + AW'(avg) - AW'(dc);
    end
    y = avg;
    if (bus.dc_en) begin
      if (diff[DW] != diff[DW-1]) begin
        y = diff[DW] ? SMIN : SMAX;
      end else begin
        y = diff[DW-1:0];
      end
    end
    ov_d      = v3_q & ~bus.clr;
    sig_out_d = sig_out_q;
    if (ov_d) begin
      sig_out_d = {~y[DW-1], y[DW-2:0]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      ov_q      <= 1'b0;
      sig_s_q   <= '0;
      car_s_q   <= '0;
      mode_q    <= 1'b0;
      m_q       <= '0;
      sum_q     <= '0;
      ptr_q     <= '0;
      dc_acc_q  <= '0;
      sig_out_q <= MID;
    end else begin
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      v3_q      <= v3_d;
      ov_q      <= ov_d;
      sig_s_q   <= sig_s_d;
      car_s_q   <= car_s_d;
      mode_q    <= mode_d;
      m_q       <= m_d;
      sum_q     <= sum_d;
      ptr_q     <= ptr_d;
      dc_acc_q  <= dc_acc_d;
      sig_out_q <= sig_out_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        box_q[i] <= '0;
      end
    end else if (bus.clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        box_q[i] <= '0;
      end
    end else if (v2_q) begin
      box_q[ptr_q] <= m_q;
    end
  end

  assign bus.out_valid = ov_q;
  assign bus.sig_out   = sig_out_q;

endmodule

// File: tb/tb_am_demod_param.sv
// Randomised bench for am_demod_param against an
// arithmetic reference model (DW=16, depth 4, DC shift 4).
module tb_am_demod_param;

  localparam int DW    = 16;
  localparam int AL    = 2;
  localparam int DS    = 4;
  localparam int DEPTH = 1 << AL;

  logic clk = 1'b0;
  logic rst = 1'b0;

  am_demod_param_if #(.DW(DW)) bus();

  am_demod_param #(
    .DW(DW),
    .AVG_LOG2(AL),
    .DC_SHIFT(DS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int     due;
    longint avg;
  } pend_t;

  pend_t       pend[$];
  longint      hist[$];
  longint      dcacc;
  int          ecnt = 0;
  logic        exp_ov;
  logic [15:0] exp_so;
  logic [15:0] outs[$];
  int          out_edge[$];

  function automatic longint fdiv(longint a, longint d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic longint mix_m(logic [15:0] s,
                                   logic [15:0] c,
                                   logic md);
    longint ss = longint'(s) - 32768;
    longint cs = longint'(c) - 32768;
    longint m;
    if (md) m = (ss < 0) ? -ss : ss;
    else    m = fdiv(ss * cs, 32768);
    if (m > 32767) m = 32767;
    return m;
  endfunction

  task automatic model_clear();
    pend.delete();
    hist.delete();
    repeat (DEPTH) hist.push_back(0);
    dcacc = 0;
  endtask

  task automatic model_reset();
    model_clear();
    exp_ov = 1'b0;
    exp_so = 16'h8000;
  endtask

  task automatic model_edge();
    pend_t  p;
    longint dc, y, sum;
    ecnt++;
    if (!rst) begin
      model_reset();
      return;
    end
    exp_ov = 1'b0;
    if (bus.clr) begin
      model_clear();
      return;
    end
    if (pend.size() > 0 && pend[0].due == ecnt) begin
      p     = pend.pop_front();
      dc    = fdiv(dcacc, 1 << DS);
      dcacc = dcacc + p.avg - dc;
      y     = bus.dc_en ? p.avg - dc : p.avg;
      if (y > 32767)  y = 32767;
      if (y < -32768) y = -32768;
      exp_so = 16'(y + 32768);
      exp_ov = 1'b1;
    end
    if (bus.in_valid) begin
      hist.push_back(mix_m(bus.sig_in, bus.carrier,
                           bus.mode));
      void'(hist.pop_front());
      sum = 0;
      foreach (hist[i]) sum += hist[i];
      pend.push_back('{ecnt + 3, fdiv(sum, DEPTH)});
    end
  endtask

  task automatic cyc(logic rs, logic iv, logic [15:0] s,
                     logic [15:0] c, logic md, logic de,
                     logic cl);
    @(negedge clk);
    rst          = rs;
    bus.in_valid = iv;
    bus.sig_in   = s;
    bus.carrier  = c;
    bus.mode     = md;
    bus.dc_en    = de;
    bus.clr      = cl;
    @(posedge clk);
    model_edge();
    #1;
    chk("out_valid", bus.out_valid, exp_ov);
    chk("sig_out", bus.sig_out, exp_so);
    if (bus.out_valid) begin
      outs.push_back(bus.sig_out);
      // high during the cycle closed by the next edge
      out_edge.push_back(ecnt + 1);
    end
  endtask

  logic [15:0] ramp_tab[4];
  logic [15:0] peak;
  int          first_in;
  int          dev;
  logic        md_r, de_r;

  initial begin
    ramp_tab[0] = 16'h8800;
    ramp_tab[1] = 16'h9000;
    ramp_tab[2] = 16'h9800;
    ramp_tab[3] = 16'hA000;
    bus.in_valid = 1'b0;
    bus.sig_in   = '0;
    bus.carrier  = '0;
    bus.mode     = 1'b0;
    bus.dc_en    = 1'b0;
    bus.clr      = 1'b0;
    model_reset();

    repeat (3)
      cyc(1'b0, 1'($urandom), 16'($urandom), 16'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom));
    repeat (2)
      cyc(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("idle_so", bus.sig_out, 16'h8000);
    chk("idle_ov", bus.out_valid, 1'b0);

    outs.delete();
    out_edge.delete();
    first_in = ecnt + 1;
    repeat (8)
      cyc(1'b1, 1'b1, 16'hC000, 16'hC000, 1'b0, 1'b0, 1'b0);
    chk("latency", out_edge.size() > 0 ?
        out_edge[0] - first_in : -1, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("ramp%0d", i),
          i < outs.size() ? outs[i] : 0, ramp_tab[i]);
    chk("ramp_steady", bus.sig_out, 16'hA000);

    repeat (8)
      cyc(1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("sat_coh", bus.sig_out, 16'hFFFF);
    repeat (8)
      cyc(1'b1, 1'b1, 16'h0000, 16'($urandom), 1'b1, 1'b0,
          1'b0);
    chk("sat_env", bus.sig_out, 16'hFFFF);

    for (int i = 0; i < 10; i++)
      cyc(1'b1, 1'b1, (i % 2) ? 16'h4000 : 16'hC000,
          16'($urandom), 1'b1, 1'b0, 1'b0);
    chk("envelope", bus.sig_out, 16'hC000);

    cyc(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1);
    peak = 16'h8000;
    repeat (310) begin
      cyc(1'b1, 1'b1, 16'hC000, 16'hC000, 1'b0, 1'b1, 1'b0);
      if (bus.sig_out > peak) peak = bus.sig_out;
    end
    chk("dc_peak", peak >= 16'h9000, 1'b1);
    dev = int'(bus.sig_out) - 32768;
    chk("dc_settle", dev <= 16 && dev >= -16, 1'b1);

    cyc(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    outs.delete();
    out_edge.delete();
    for (int i = 0; i < 15; i++)
      cyc(1'b1, (i % 3) == 0, 16'hC000, 16'hC000, 1'b0, 1'b0,
          1'b0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("stall%0d", i),
          i < outs.size() ? outs[i] : 0, ramp_tab[i]);
    chk("stall_gap", out_edge.size() > 1 ?
        out_edge[1] - out_edge[0] : -1, 3);

    repeat (10)
      cyc(1'b1, 1'b1, 16'hC000, 16'hC000, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 16'hC000, 16'hC000, 1'b0, 1'b0, 1'b1);
    chk("clr_ov", bus.out_valid, 1'b0);
    outs.delete();
    repeat (6)
      cyc(1'b1, 1'b1, 16'hC000, 16'hC000, 1'b0, 1'b0, 1'b0);
    chk("clr_restart", outs.size() > 0 ? outs[0] : 0,
        16'h8800);

    repeat (6)
      cyc(1'b1, 1'b1, 16'hC000, 16'hC000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    chk("arst_ov", bus.out_valid, 1'b0);
    chk("arst_so", bus.sig_out, 16'h8000);
    repeat (2)
      cyc(1'b0, 1'b1, 16'hC000, 16'hC000, 1'b0, 1'b0, 1'b0);

    md_r = 1'b0;
    de_r = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) md_r = ~md_r;
      if ($urandom_range(0, 19) == 0) de_r = ~de_r;
      cyc($urandom_range(0, 149) != 0,
          $urandom_range(0, 9) < 7,
          16'($urandom), 16'($urandom), md_r, de_r,
          $urandom_range(0, 39) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/am_demod_param.md
Name: am_demod_param

Overview:
- Parametrised coherent/envelope AM demodulator for the DDS signal chain, next to the DDS carrier generator.
- Takes offset-binary modulated signal and carrier samples with a valid strobe.
- Pipeline: mix (or rectify), boxcar low-pass of configurable depth, optional DC-removal loop.
- Returns an offset-binary baseband sample with a valid strobe.

Parameters:
- DW, 16, sample width of sig_in, carrier and sig_out (offset-binary).
- AVG_LOG2, 4, log2 of moving-average depth; depth = 2^AVG_LOG2, legal range 1..8.
- DC_SHIFT, 6, leaky-integrator shift of the DC-removal loop, legal range 2..12.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  sig_in/carrier hold a new sample this cycle.
- sig_in  input  DW  modulated signal, offset-binary.
- carrier  input  DW  coherent carrier, offset-binary; ignored in envelope mode.
- mode  input  1  0 = coherent (sig_in × carrier), 1 = envelope (|sig_in|); sampled with each accepted sample.
- dc_en  input  1  1 = subtract DC estimate from output.
- clr  input  1  synchronous clear of filter history and DC estimate.
- out_valid  output  1  sig_out updated this cycle.
- sig_out  output  DW  demodulated baseband, offset-binary.

Behaviour:
- Reset (rst low, async): all pipeline registers, the boxcar buffer, running sum and DC accumulator go to 0. out_valid=0. sig_out=2^(DW-1) (16'h8000). Takes effect immediately, mid-operation included.
- Pipeline advances only on in_valid. Stage valids are a shift chain of in_valid. Total latency is 4 cycles: an in_valid at cycle n gives out_valid at n+4. Gaps insert bubbles and hold all history.
- S1, convert: invert MSB of sig_in and carrier to get signed two's complement. Register with mode.
- S2, mix:
  - Coherent: p = sig_s × car_s (2DW signed); m = p[2DW-2:DW-1] (Q1.(DW-1)). The sole overflow case, (−2^(DW-1))², saturates to 2^(DW-1)−1.
  - Envelope: m = |sig_s|; −2^(DW-1) saturates to 2^(DW-1)−1.
- S3, boxcar:
  - Circular buffer of 2^AVG_LOG2 DW-bit entries plus a write pointer that wraps modulo depth.
  - sum (DW+AVG_LOG2 signed) <= sum + m − buf[ptr]; then buf[ptr] <= m and ptr increments.
  - avg = sum >>> AVG_LOG2 (arithmetic).
  - No fill gating: the first depth−1 outputs include the zero history.
- S4, DC removal:
  - dc_acc (DW+DC_SHIFT signed) <= dc_acc + avg − (dc_acc >>> DC_SHIFT); dc = dc_acc >>> DC_SHIFT.
  - dc_acc updates on every S4-valid regardless of dc_en.
  - y = dc_en ? avg − dc : avg, saturated to signed DW.
  - sig_out <= y + 2^(DW-1) (MSB invert); out_valid <= 1 for that one cycle.
- out_valid is 0 on every non-update cycle; sig_out holds its last value.
- clr:
  - Zeroes the buffer, sum, ptr, dc_acc and the S1–S3 valids on that edge.
  - A sample presented with clr is discarded.
  - sig_out holds its value; out_valid is 0 the following cycle.
- clr and rst together: rst wins.
- A mode change mid-stream takes effect on the next accepted sample. History is not flushed; the user asserts clr if required.

Test Plan:
- Reset: hold rst low for 3 cycles with random inputs → out_valid=0 and sig_out=16'h8000 throughout; release, no in_valid → outputs unchanged.
- Coherent ramp (DW=16, AVG_LOG2=2, dc_en=0, mode=0): sig_in=carrier=16'hC000, in_valid continuous → first out_valid exactly 4 cycles after first in_valid; sig_out sequence 16'h8800, 16'h9000, 16'h9800, then 16'hA000 steady.
- Saturation: sig_in=carrier=16'h0000, mode=0 → steady sig_out=16'hFFFF, no wrap to 16'h0000. Mode=1 with sig_in=16'h0000 → steady 16'hFFFF.
- Envelope: mode=1, sig_in alternating 16'hC000/16'h4000 → steady sig_out=16'hC000; carrier toggled randomly has no effect.
- DC removal (DC_SHIFT=4, dc_en=1): constant setup from the coherent-ramp test → output peaks, then decays; |sig_out−32768| ≤ 16 after 300 valid samples.
- Stall/clear/reset: in_valid 1-in-3 in the coherent-ramp setup → identical output values, out_valid spacing follows input spacing. clr after steady state → next outputs restart 16'h8800…. rst pulse mid-stream → immediate 16'h8000, out_valid=0.
